// File: rtl/mem_uart_bridge_if.sv
// Memory-request bus between a requester and the UART bridge.
// Handshake: write_enable/read_enable are level requests held by the master until it sees
// mem_done or mem_err; the bridge then waits for both enables low before it accepts again.
interface mem_uart_bridge_if #(
   parameter int ADDR_W     = 8,
   parameter int DATA_BYTES = 4
);
   logic                      write_enable;
   logic                      read_enable;
   logic [ADDR_W-1:0]         address;
   logic [8*DATA_BYTES-1:0]   writeData;
   logic [1:0]                xfer_size;
   logic [8*DATA_BYTES-1:0]   readData;
   logic                      mem_done;
   logic                      mem_err;
   logic                      busy;

   modport master (
      output write_enable, read_enable, address, writeData, xfer_size,
      input  readData, mem_done, mem_err, busy
   );

   modport slave (
      input  write_enable, read_enable, address, writeData, xfer_size,
      output readData, mem_done, mem_err, busy
   );
endinterface

// File: rtl/mem_uart_bridge.sv
// Bridges memory read/write requests onto an 8N1 UART link: sends a command/address/data
// frame on tx and, for reads, collects the reply bytes from rx with a timeout.
module mem_uart_bridge #(
   parameter int CLKS_PER_BIT = 4,
   parameter int ADDR_W       = 8,
   parameter int DATA_BYTES   = 4,
   parameter int TIMEOUT_CYC  = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   output logic             tx,
   mem_uart_bridge_if.slave bus,
   output logic [2:0]       state_dbg
);
   localparam int ABYTES = ADDR_W / 8;
   localparam int DW     = 8 * DATA_BYTES;
   localparam int CW     = $clog2(CLKS_PER_BIT);
   localparam int TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CLK_HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [1:0]    NB_MAX   = 2'(DATA_BYTES - 1);

   typedef enum logic [2:0] {IDLE, SEND, RECV, FINISH, WAIT_REL} state_t;

   state_t            state;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DW-1:0]     wdata_q;
   logic [1:0]        nb_m1_q;
   logic [3:0]        nb_total_q;
   logic [CW-1:0]     clk_cnt;
   logic [3:0]        bit_idx;
   logic [3:0]        byte_idx;
   logic              rx_s1, rx_s2, rx_prev;
   logic              rx_active;
   logic [CW-1:0]     rx_cnt;
   logic [3:0]        rx_bit;
   logic [7:0]        rx_shift;
   logic [1:0]        rx_byte;
   logic [DW-1:0]     shadow;
   logic [TW-1:0]     to_cnt;

   logic [1:0]        req_nb_m1;
   logic [3:0]        req_total;
   logic [7:0]        frame_byte;
   logic [DW-1:0]     shadow_next;
   logic              rx_stop_now;

   assign state_dbg = state;

   always_comb begin
      req_nb_m1 = (bus.xfer_size > NB_MAX) ? NB_MAX : bus.xfer_size;
      req_total = 4'(1 + ABYTES) + (bus.write_enable ? (4'(req_nb_m1) + 4'd1) : 4'd0);
   end

   // Byte 0 is the command, then address MSB first, then write data LSB first.
   always_comb begin
      frame_byte = {rw_q, 5'b0, nb_m1_q};
      for (int i = 0; i < ABYTES; i++)
         if (byte_idx == 4'(i + 1)) frame_byte = addr_q[(ABYTES-1-i)*8 +: 8];
      for (int i = 0; i < DATA_BYTES; i++)
         if (byte_idx == 4'(1 + ABYTES + i)) frame_byte = wdata_q[i*8 +: 8];
   end

   always_comb begin
      shadow_next = shadow;
      for (int i = 0; i < DATA_BYTES; i++)
         if (rx_byte == 2'(i)) shadow_next[i*8 +: 8] = rx_shift;
      rx_stop_now = rx_active && (rx_cnt == CLK_LAST) && (rx_bit == 4'd9);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         tx           <= 1'b1;
         bus.mem_done <= 1'b0;
         bus.mem_err  <= 1'b0;
         bus.busy     <= 1'b0;
         bus.readData <= '0;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         nb_m1_q      <= '0;
         nb_total_q   <= '0;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         byte_idx     <= '0;
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b1;
         rx_active    <= 1'b0;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_byte      <= '0;
         shadow       <= '0;
         to_cnt       <= '0;
      end else begin
         rx_s1        <= rx;
         rx_s2        <= rx_s1;
         rx_prev      <= rx_s2;
         bus.mem_done <= 1'b0;
         bus.mem_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.write_enable || bus.read_enable) begin
                  rw_q       <= bus.write_enable;
                  addr_q     <= bus.address;
                  wdata_q    <= bus.writeData;
                  nb_m1_q    <= req_nb_m1;
                  nb_total_q <= req_total;
                  clk_cnt    <= '0;
                  bit_idx    <= '0;
                  byte_idx   <= '0;
                  shadow     <= '0;
                  tx         <= 1'b0;
                  bus.busy   <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (clk_cnt == CLK_LAST) begin
                  clk_cnt <= '0;
                  if (bit_idx == 4'd9) begin
                     if (byte_idx == nb_total_q - 4'd1) begin
                        if (rw_q) begin
                           bus.mem_done <= 1'b1;
                           state        <= FINISH;
                        end else begin
                           to_cnt    <= '0;
                           rx_active <= 1'b0;
                           rx_byte   <= '0;
                           state     <= RECV;
                        end
                     end else begin
                        byte_idx <= byte_idx + 4'd1;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     tx      <= (bit_idx == 4'd8) ? 1'b1 : frame_byte[bit_idx[2:0]];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            RECV: begin
               to_cnt <= to_cnt + TW'(1);
               // A stop bit landing on the timeout cycle takes precedence over the timeout.
               if (!rx_stop_now && to_cnt == TO_LAST) begin
                  bus.mem_err <= 1'b1;
                  state       <= FINISH;
               end
               if (!rx_active) begin
                  if (rx_prev && !rx_s2) begin
                     rx_active <= 1'b1;
                     rx_cnt    <= CLK_HALF;
                     rx_bit    <= '0;
                  end
               end else if (rx_cnt == CLK_LAST) begin
                  rx_cnt <= '0;
                  if (rx_bit == 4'd0) begin
                     if (rx_s2) rx_active <= 1'b0;
                     else       rx_bit    <= 4'd1;
                  end else if (rx_bit != 4'd9) begin
                     rx_shift <= {rx_s2, rx_shift[7:1]};
                     rx_bit   <= rx_bit + 4'd1;
                  end else begin
                     rx_active <= 1'b0;
                     if (rx_s2) begin
                        shadow <= shadow_next;
                        to_cnt <= '0;
                        if (rx_byte == nb_m1_q) begin
                           bus.readData <= shadow_next;
                           bus.mem_done <= 1'b1;
                           state        <= FINISH;
                        end else begin
                           rx_byte <= rx_byte + 2'd1;
                        end
                     end else begin
                        bus.mem_err <= 1'b1;
                        state       <= FINISH;
                     end
                  end
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            FINISH: state <= WAIT_REL;
            WAIT_REL: begin
               if (!bus.write_enable && !bus.read_enable) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
